// File: rtl/serial_bit_streamer_if.sv
// Handshake and serial-output bundle for serial_bit_streamer.
// The producer/consumer side takes the master modport; the streamer takes slave.
interface serial_bit_streamer_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         bit_en;
  logic         out_bit;
  logic         out_valid;
  logic         word_start;

  modport master (
    output in_data,
    output in_valid,
    output bit_en,
    input  in_ready,
    input  out_bit,
    input  out_valid,
    input  word_start
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  bit_en,
    output in_ready,
    output out_bit,
    output out_valid,
    output word_start
  );
endinterface

// File: rtl/serial_bit_streamer.sv
// Parallel-to-serial front end: one-word holding register feeding a shifter that
// emits one bit per bit_en cycle, gapless across back-to-back words.
module serial_bit_streamer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_bit_streamer_if.slave bus
);

  localparam int          CW       = $clog2(W + 1);
  localparam int          OUT_IDX  = MSB_FIRST ? W - 1 : 0;
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_full_q, hold_full_d;

  logic [W-1:0]  shifted;
  logic          out_valid, out_bit, word_start, in_ready;
  logic          accept, consume, last, drain;

  always_ff @(posedge clk) begin
    shift_q     <= shift_d;
    hold_q      <= hold_d;
    cnt_q       <= cnt_d;
    hold_full_q <= hold_full_d;
  end

  always_comb begin
    out_valid  = (cnt_q != '0);
    out_bit    = out_valid & shift_q[OUT_IDX];
    word_start = out_valid & (cnt_q == CNT_FULL);
    in_ready   = ~rst & ~hold_full_q;

    accept  = bus.in_valid & in_ready;
    consume = out_valid & bus.bit_en;
    last    = consume & (cnt_q == CNT_ONE);
    drain   = (cnt_q == '0) | last;

    shifted = MSB_FIRST ? {shift_q[W-2:0], 1'b0} : {1'b0, shift_q[W-1:1]};

    shift_d     = shift_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;

    if (rst) begin
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else if (drain) begin
      // Reload the shifter on the same edge the last bit leaves, so no gap appears.
      if (hold_full_q) begin
        shift_d     = hold_q;
        cnt_d       = CNT_FULL;
        hold_full_d = accept;
        if (accept) hold_d = bus.in_data;
      end else if (accept) begin
        shift_d = bus.in_data;
        cnt_d   = CNT_FULL;
      end else begin
        cnt_d = '0;
      end
    end else begin
      if (consume) begin
        shift_d = shifted;
        cnt_d   = cnt_q - CNT_ONE;
      end
      if (accept) begin
        hold_d      = bus.in_data;
        hold_full_d = 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_bit    = out_bit;
  assign bus.out_valid  = out_valid;
  assign bus.word_start = word_start;

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Directed bench for serial_bit_streamer: reset, single word, back-to-back words,
// paced output, mid-word reset, LSB-first and narrow-word variants.
module tb_serial_bit_streamer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_bit_streamer_if #(.W(8)) bus_a ();
  serial_bit_streamer_if #(.W(8)) bus_b ();
  serial_bit_streamer_if #(.W(4)) bus_c ();

  serial_bit_streamer #(.W(8), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  serial_bit_streamer #(.W(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  serial_bit_streamer #(.W(4), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic en);
    bus_a.in_valid = valid;
    bus_a.in_data  = data;
    bus_a.bit_en   = en;
  endtask

  logic [7:0] words [3];
  logic [7:0] w;
  int         widx;
  int         k;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.bit_en = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.bit_en = 1'b1;

    // reset held for two edges, then one idle cycle
    @(negedge clk);
    checkOutput("t1 ready in rst c0", bus_a.in_ready, 0);
    @(negedge clk);
    checkOutput("t1 ready in rst c1", bus_a.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t1 out_valid", bus_a.out_valid, 0);
    checkOutput("t1 out_bit", bus_a.out_bit, 0);
    checkOutput("t1 word_start", bus_a.word_start, 0);
    checkOutput("t1 in_ready", bus_a.in_ready, 1);

    // single word 0xCC
    w = 8'hCC;
    checkOutput("t2 ready c0", bus_a.in_ready, 1);
    applyStimulus(1'b1, w, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b0, 8'h00, 1'b1);
      if (i <= 8) begin
        checkOutput($sformatf("t2 valid c%0d", i), bus_a.out_valid, 1);
        checkOutput($sformatf("t2 bit c%0d", i), bus_a.out_bit, {31'd0, w[8-i]});
        checkOutput($sformatf("t2 ws c%0d", i), bus_a.word_start, (i == 1) ? 1 : 0);
      end else begin
        checkOutput("t2 valid c9", bus_a.out_valid, 0);
      end
    end

    // three back-to-back words, in_valid held while words remain
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    widx = 0;
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= 24) begin
        w = words[(c-1)/8];
        k = (c - 1) % 8;
        checkOutput($sformatf("t3 valid c%0d", c), bus_a.out_valid, 1);
        checkOutput($sformatf("t3 bit c%0d", c), bus_a.out_bit, {31'd0, w[7-k]});
        checkOutput($sformatf("t3 ws c%0d", c), bus_a.word_start, (k == 0) ? 1 : 0);
      end
      if (c == 25) checkOutput("t3 valid c25", bus_a.out_valid, 0);
      if (c <= 9)
        checkOutput($sformatf("t3 ready c%0d", c), bus_a.in_ready,
                    (c == 0 || c == 1 || c == 9) ? 1 : 0);
      if (widx < 3) applyStimulus(1'b1, words[widx], 1'b1);
      else          applyStimulus(1'b0, 8'h00, 1'b1);
      if (widx < 3 && (c == 0 || c == 1 || c == 9)) widx++;
    end

    // 0xF0 with bit_en high only on even cycles: each bit shown twice
    w = 8'hF0;
    applyStimulus(1'b1, w, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, (c % 2) == 0);
      if (c <= 16) begin
        k = (c - 1) / 2;
        checkOutput($sformatf("t4 valid c%0d", c), bus_a.out_valid, 1);
        checkOutput($sformatf("t4 bit c%0d", c), bus_a.out_bit, {31'd0, w[7-k]});
        checkOutput($sformatf("t4 ws c%0d", c), bus_a.word_start, (k == 0) ? 1 : 0);
      end else begin
        checkOutput("t4 valid c17", bus_a.out_valid, 0);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1);

    // 0xF0 streaming, 0x0F held, reset after three bits
    applyStimulus(1'b1, 8'hF0, 1'b1);
    @(negedge clk);
    checkOutput("t5 ready c1", bus_a.in_ready, 1);
    applyStimulus(1'b1, 8'h0F, 1'b1);
    checkOutput("t5 bit c1", bus_a.out_bit, 1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t5 ready c2", bus_a.in_ready, 0);
    checkOutput("t5 bit c2", bus_a.out_bit, 1);
    @(negedge clk);
    checkOutput("t5 bit c3", bus_a.out_bit, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5 ready in rst", bus_a.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5 valid after rst", bus_a.out_valid, 0);
    checkOutput("t5 bit after rst", bus_a.out_bit, 0);
    checkOutput("t5 ws after rst", bus_a.word_start, 0);
    @(negedge clk);
    checkOutput("t5 valid idle", bus_a.out_valid, 0);
    w = 8'h81;
    applyStimulus(1'b1, w, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b0, 8'h00, 1'b1);
      if (i <= 8) begin
        checkOutput($sformatf("t5 valid b%0d", i), bus_a.out_valid, 1);
        checkOutput($sformatf("t5 bit b%0d", i), bus_a.out_bit, {31'd0, w[8-i]});
      end else begin
        checkOutput("t5 valid end", bus_a.out_valid, 0);
      end
    end

    // LSB-first 0x01 on dut_b
    bus_b.in_valid = 1'b1; bus_b.in_data = 8'h01;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      bus_b.in_valid = 1'b0;
      if (i <= 8) begin
        checkOutput($sformatf("t6b valid c%0d", i), bus_b.out_valid, 1);
        checkOutput($sformatf("t6b bit c%0d", i), bus_b.out_bit, (i == 1) ? 1 : 0);
      end else begin
        checkOutput("t6b valid c9", bus_b.out_valid, 0);
      end
    end

    // 4-bit 0xA on dut_c
    bus_c.in_valid = 1'b1; bus_c.in_data = 4'hA;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus_c.in_valid = 1'b0;
      if (i <= 4) begin
        checkOutput($sformatf("t6c valid c%0d", i), bus_c.out_valid, 1);
        checkOutput($sformatf("t6c bit c%0d", i), bus_c.out_bit, (i % 2 == 1) ? 1 : 0);
        checkOutput($sformatf("t6c ws c%0d", i), bus_c.word_start, (i == 1) ? 1 : 0);
      end else begin
        checkOutput("t6c valid c5", bus_c.out_valid, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
